rf_multiport: RTL and testbench

- Parametrised successor to the core's 2-read/1-write register file.
- Generalised in data width, depth and number of synchronous read ports, with optional hardwired-zero entry 0 and optional write-to-read bypass.
- Adds a reset/clear sequencer that zeroes every entry, plus ready and drop status outputs.
- Sits in the decode stage, between instruction decode and the ALU operand latches.

---
 rtl/rf_multiport_if.sv | 32 +++
 rtl/rf_multiport.sv | 114 +++++++++++
 tb/tb_rf_multiport.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rf_multiport_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_multiport_if
// Brief    : Control, address/data and status bundle of the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                         ctrl_clear;
  logic                         ctrl_reg_write_enable;
  logic [ADDR_WIDTH-1:0]        write_reg;
  logic [DATA_WIDTH-1:0]        write_data;
  logic [NUM_RD*ADDR_WIDTH-1:0] read_reg;
  logic [NUM_RD*DATA_WIDTH-1:0] read_data;
  logic                         stat_reg_write_done;
  logic                         stat_ready;
  logic                         stat_write_dropped;

  modport master (
    output ctrl_clear, ctrl_reg_write_enable, write_reg, write_data, read_reg,
    input  read_data, stat_reg_write_done, stat_ready, stat_write_dropped
  );

  modport slave (
    input  ctrl_clear, ctrl_reg_write_enable, write_reg, write_data, read_reg,
    output read_data, stat_reg_write_done, stat_ready, stat_write_dropped
  );
endinterface
`default_nettype wire

// File: rtl/rf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : rf_multiport
// Brief    : Parametrised multi-read register file with clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module rf_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_multiport_if.slave bus
);
  localparam int                    c_depth    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_ptr = '1;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                       r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]        r_clear_ptr, w_clear_ptr_next;
  logic [DATA_WIDTH-1:0]        r_mem [c_depth];
  logic [NUM_RD*DATA_WIDTH-1:0] r_rd_data, w_rd_next;
  logic                         r_done, r_dropped, r_ready;
  logic                         w_done, w_dropped, w_wr_accept;
  logic                         w_mem_we;
  logic [ADDR_WIDTH-1:0]        w_mem_addr;
  logic [DATA_WIDTH-1:0]        w_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLEAR;
      r_clear_ptr <= '0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_dropped   <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clear_ptr <= w_clear_ptr_next;
      r_rd_data   <= w_rd_next;
      r_done      <= w_done;
      r_dropped   <= w_dropped;
      r_ready     <= (w_state_next == ST_READY);
    end
  end

  // Storage has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_comb begin
    w_state_next     = r_state;
    w_clear_ptr_next = r_clear_ptr;
    w_done           = 1'b0;
    w_dropped        = 1'b0;
    w_wr_accept      = 1'b0;
    w_mem_we         = 1'b0;
    w_mem_addr       = bus.write_reg;
    w_mem_wdata      = bus.write_data;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clear_ptr;
        w_mem_wdata = '0;
        w_dropped   = bus.ctrl_reg_write_enable;
        if (bus.ctrl_clear) begin
          w_clear_ptr_next = '0;
        end else if (r_clear_ptr == c_last_ptr) begin
          w_clear_ptr_next = '0;
          w_state_next     = ST_READY;
        end else begin
          w_clear_ptr_next = r_clear_ptr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (bus.ctrl_clear) begin
          // A clear outranks a coincident write.
          w_state_next     = ST_CLEAR;
          w_clear_ptr_next = '0;
          w_dropped        = bus.ctrl_reg_write_enable;
        end else if (bus.ctrl_reg_write_enable) begin
          w_wr_accept = 1'b1;
          w_done      = 1'b1;
          w_mem_we    = !((ZERO_REG != 0) && (bus.write_reg == '0));
        end
      end
    endcase
  end

  always_comb begin
    w_rd_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((r_state == ST_READY) &&
          !((ZERO_REG != 0) && (bus.read_reg[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
        if ((BYPASS != 0) && w_wr_accept &&
            (bus.write_reg == bus.read_reg[i*ADDR_WIDTH +: ADDR_WIDTH]))
          w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
        else
          w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[bus.read_reg[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  assign bus.read_data           = r_rd_data;
  assign bus.stat_reg_write_done = r_done;
  assign bus.stat_write_dropped  = r_dropped;
  assign bus.stat_ready          = r_ready;
endmodule
`default_nettype wire

// File: tb/tb_rf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_multiport
// Brief    : Bench for rf_multiport: bypassing/zero-reg and plain variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_multiport;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        t_clr = 1'b0, t_we = 1'b0;
  logic [4:0]  t_wa = '0, t_ra0 = '0, t_ra1 = '0;
  logic [31:0] t_wd = '0;

  rf_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifa ();
  rf_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifb ();

  assign ifa.ctrl_clear = t_clr;  assign ifb.ctrl_clear = t_clr;
  assign ifa.ctrl_reg_write_enable = t_we;  assign ifb.ctrl_reg_write_enable = t_we;
  assign ifa.write_reg = t_wa;  assign ifb.write_reg = t_wa;
  assign ifa.write_data = t_wd;  assign ifb.write_data = t_wd;
  assign ifa.read_reg = {t_ra1, t_ra0};  assign ifb.read_reg = {t_ra1, t_ra0};

  rf_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  rf_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Reference: a file is either usable or counting down its clear time.
  int          n_checks = 0, n_err = 0;
  bit          m_ready;
  int          m_left;
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [63:0] e_rd_a, e_rd_b;
  logic        e_done, e_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_left = 32;
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    e_rd_a = '0; e_rd_b = '0; e_done = 0; e_drop = 0;
  endtask

  task automatic model_step();
    logic [4:0] ra [2];
    bit acc;
    ra[0] = t_ra0; ra[1] = t_ra1;
    e_rd_a = '0; e_rd_b = '0;
    if (!m_ready) begin
      e_done = 0; e_drop = t_we;
      if (t_clr) m_left = 32;
      else begin
        m_left--;
        if (m_left == 0) m_ready = 1;
      end
    end else begin
      acc = t_we && !t_clr;
      for (int p = 0; p < 2; p++) begin
        if (ra[p] != 0) e_rd_a[p*32 +: 32] = (acc && t_wa == ra[p]) ? t_wd : mem_a[ra[p]];
        e_rd_b[p*32 +: 32] = mem_b[ra[p]];
      end
      e_done = acc; e_drop = t_we && t_clr;
      if (acc) begin
        if (t_wa != 0) mem_a[t_wa] = t_wd;
        mem_b[t_wa] = t_wd;
      end
      if (t_clr) begin
        m_ready = 0; m_left = 32;
        for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      end
    end
  endtask

  task automatic check_all();
    chk("rd_a",    ifa.read_data, e_rd_a);
    chk("rd_b",    ifb.read_data, e_rd_b);
    chk("done_a",  64'(ifa.stat_reg_write_done), 64'(e_done));
    chk("done_b",  64'(ifb.stat_reg_write_done), 64'(e_done));
    chk("drop_a",  64'(ifa.stat_write_dropped), 64'(e_drop));
    chk("drop_b",  64'(ifb.stat_write_dropped), 64'(e_drop));
    chk("ready_a", 64'(ifa.stat_ready), 64'(m_ready));
    chk("ready_b", 64'(ifb.stat_ready), 64'(m_ready));
  endtask

  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra0, input logic [4:0] ra1, input bit clr);
    t_we = we; t_wa = wa; t_wd = wd; t_ra0 = ra0; t_ra1 = ra1; t_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 5'd1, 5'd2, 0);
  endtask

  // Assert rst_n mid-cycle and check outputs fall before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clear sequence after reset, then every entry reads zero.
    idle(32);
    chk("ready_after_32", 64'(ifa.stat_ready), 64'd1);
    for (int i = 0; i < 32; i++) cyc(0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 0);

    // Write then read on both ports.
    cyc(1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 0);
    cyc(0, 5'd0, 32'd0, 5'd5, 5'd5, 0);
    cyc(0, 5'd0, 32'd0, 5'd5, 5'd5, 0);
    chk("r5_port0", 64'(ifa.read_data[31:0]), 64'hDEADBEEF);

    // Same-cycle read of the written register on port 1.
    cyc(1, 5'd7, 32'h12345678, 5'd5, 5'd7, 0);
    chk("bypass_a", 64'(ifa.read_data[63:32]), 64'h12345678);
    chk("nobypass_b", 64'(ifb.read_data[63:32]), 64'h0);
    cyc(0, 5'd0, 32'd0, 5'd7, 5'd7, 0);

    // Zero register.
    cyc(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 0);
    cyc(0, 5'd0, 32'd0, 5'd0, 5'd0, 0);
    chk("r0_a", 64'(ifa.read_data[31:0]), 64'h0);

    // Clear collides with a write.
    cyc(1, 5'd3, 32'h11112222, 5'd3, 5'd3, 0);
    cyc(1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 1);
    chk("clr_drop", 64'(ifa.stat_write_dropped), 64'd1);
    idle(32);
    cyc(0, 5'd0, 32'd0, 5'd3, 5'd3, 0);
    chk("r3_cleared", ifa.read_data, 64'h0);

    // Reset while READY with live outputs.
    cyc(1, 5'd9, 32'h000055AA, 5'd9, 5'd4, 0);
    cyc(0, 5'd0, 32'd0, 5'd9, 5'd9, 0);
    async_reset();

    // Reset during CLEAR at pointer 10, with a dropped write just before.
    idle(9);
    cyc(1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd12, 0);
    chk("clear_drop", 64'(ifa.stat_write_dropped), 64'd1);
    async_reset();
    idle(31);
    chk("not_ready_31", 64'(ifa.stat_ready), 64'd0);
    idle(1);
    chk("ready_32", 64'(ifa.stat_ready), 64'd1);

    // Randomised traffic, narrow address window to exercise collisions.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] msk;
      msk = ($urandom_range(0, 1) == 0) ? 5'h03 : 5'h1F;
      cyc($urandom_range(0, 2) != 0, 5'($urandom) & msk, $urandom,
          5'($urandom) & msk, 5'($urandom) & msk, $urandom_range(0, 79) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
